// File: rtl/mips_result_capture.sv
// ---------------------------------------------------------------------------
// mips_result_capture
//
// Watches the processor's 32-bit result bus. Every new value goes into a
// show-ahead FIFO, which a downstream reader drains over a valid/ready port.
// A value counts as new when it differs from the last enabled sample, or when
// it is the first enabled sample after reset. A new value that finds the FIFO
// full, with no pop on the same edge, is dropped. Dropped values set a sticky
// overflow flag and advance a saturating drop counter.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high; clears all state
//   result       in   [31:0] processor result bus, sampled every edge
//   capture_en   in   gates pushes and change-detector updates
//   rd_valid     out  FIFO non-empty
//   rd_ready     in   reader accepts the head entry when rd_valid is high
//   rd_data      out  [31:0] head entry (show-ahead); 0 while empty
//   level        out  [log2(DEPTH):0] occupancy, 0..DEPTH
//   full         out  level == DEPTH
//   overflow     out  sticky, at least one value dropped since reset
//   drop_count   out  [CNT_W-1:0] dropped values, saturating
//   total_count  out  [31:0] accepted values, wraps
// ---------------------------------------------------------------------------
module mips_result_capture #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              result,
    input  logic                     capture_en,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic [31:0]              total_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    // Change detector
    logic [31:0]      last_q, last_d;
    logic             seen_q, seen_d;

    // FIFO bookkeeping
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    // Accounting
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [31:0]      total_q, total_d;

    logic [31:0]      mem [DEPTH];

    logic req, pop, push, drop;

    // Every handshake term comes from registered state and the current
    // inputs. rd_valid and full therefore never see rd_ready or result
    // combinationally.
    assign rd_valid = (level_q != '0);
    assign full     = (level_q == LEVEL_FULL);
    assign req      = capture_en && (!seen_q || (result != last_q));
    assign pop      = rd_valid && rd_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push     = req && (!full || pop);
    assign drop     = req && full && !pop;

    // NOTE: every variable written here gets a default first. An assignment
    // missing on any path would infer a latch.
    always_comb begin
        last_d     = last_q;
        seen_d     = seen_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        total_d    = total_q;

        // The last value follows the bus even on a drop. A held value is
        // then not requested again on the next cycle.
        if (capture_en) begin
            last_d = result;
            seen_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            total_d  = total_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (!(&drop_q)) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge value, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= '0;
            seen_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            total_q    <= '0;
        end else begin
            last_q     <= last_d;
            seen_q     <= seen_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            total_q    <= total_d;
        end
    end

    // NOTE: the storage array has no reset. A write during reset is harmless
    // because the pointers and level restart at 0. The read port masks the
    // stale entries while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= result;
        end
    end

    assign rd_data     = rd_valid ? mem[rd_ptr_q] : 32'd0;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;
    assign total_count = total_q;

endmodule
